// File: rtl/mac_arbiter_if.sv
// Handshake and data bundle between two job requesters, the arbiter and a shared MAC unit.
// The slave modport is the arbiter's view; master is the requester/MAC environment.
interface mac_arbiter_if;
    logic [1:0]  req;
    logic [1:0]  req_mode;
    logic [15:0] req_len;
    logic [1:0]  gnt;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [1:0]  op_valid;
    logic [1:0]  op_ready;
    logic        mac_config_en;
    logic        mac_float_int;
    logic [7:0]  mac_data_num;
    logic [15:0] mac_in_a;
    logic [15:0] mac_in_b;
    logic        mac_in_valid_a;
    logic        mac_in_valid_b;
    logic        mac_out_valid;
    logic [15:0] mac_out;
    logic [15:0] res_data;
    logic [1:0]  res_valid;
    logic        busy;
    logic [1:0]  err;

    modport slave (
        input  req, req_mode, req_len, op_a, op_b, op_valid, mac_out_valid, mac_out,
        output gnt, op_ready, mac_config_en, mac_float_int, mac_data_num,
               mac_in_a, mac_in_b, mac_in_valid_a, mac_in_valid_b,
               res_data, res_valid, busy, err
    );

    modport master (
        output req, req_mode, req_len, op_a, op_b, op_valid, mac_out_valid, mac_out,
        input  gnt, op_ready, mac_config_en, mac_float_int, mac_data_num,
               mac_in_a, mac_in_b, mac_in_valid_a, mac_in_valid_b,
               res_data, res_valid, busy, err
    );
endinterface

// File: rtl/mac_arbiter.sv
// Two-requester round-robin arbiter owning one MAC for a whole job (configure, stream, result).
// Define MAC_ARB_TIMEOUT_EN to abort a job with err[g] when the MAC result never arrives.
module mac_arbiter #(
    parameter int TIMEOUT_CYC = 1023
) (
    input  logic          clk,
    input  logic          rst_n,
    mac_arbiter_if.slave  bus
);

    typedef enum logic [2:0] {IDLE, CONF, STREAM, WAIT, DONE} state_t;

    state_t      r_state, w_next;
    logic        r_pri;
    logic [1:0]  r_gnt;
    logic        r_mode;
    logic [7:0]  r_len;
    logic [7:0]  r_cnt;
    logic        r_conf;
    logic [15:0] r_in_a, r_in_b;
    logic        r_in_vld;
    logic [15:0] r_res;
    logic [1:0]  r_res_vld;

    logic        w_win;
    logic        w_sel;
    logic        w_beat;
    logic        w_last;
    logic        w_tmo;

    // Preferred requester wins when it asks; otherwise the other one gets the MAC.
    assign w_win  = bus.req[r_pri] ? r_pri : ~r_pri;
    assign w_sel  = r_gnt[1];
    assign w_beat = (r_state == STREAM) && bus.op_valid[w_sel];
    // Length 0 wraps to 255 here, so it terminates on the 256th beat.
    assign w_last = w_beat && (r_cnt == r_len - 8'd1);

`ifdef MAC_ARB_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);

    logic [TW-1:0] r_tcnt;
    logic [1:0]    r_err;

    assign w_tmo = (r_state == WAIT) && !bus.mac_out_valid &&
                   (r_tcnt == TW'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tcnt <= '0;
            r_err  <= '0;
        end else begin
            r_tcnt <= (r_state == WAIT) ? r_tcnt + 1'b1 : '0;
            r_err  <= w_tmo ? r_gnt : 2'b00;
        end
    end

    assign bus.err = r_err;
`else
    logic w_unused_tmo;

    assign w_tmo        = 1'b0;
    assign w_unused_tmo = (TIMEOUT_CYC == 0);
    assign bus.err      = 2'b00;
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (|bus.req) w_next = CONF;
            CONF:    if (r_conf) w_next = STREAM;
            STREAM:  if (w_last) w_next = WAIT;
            WAIT:    if (bus.mac_out_valid || w_tmo) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_pri     <= 1'b0;
            r_gnt     <= '0;
            r_mode    <= 1'b0;
            r_len     <= '0;
            r_cnt     <= '0;
            r_conf    <= 1'b0;
            r_in_a    <= '0;
            r_in_b    <= '0;
            r_in_vld  <= 1'b0;
            r_res     <= '0;
            r_res_vld <= '0;
        end else begin
            r_state   <= w_next;
            r_in_vld  <= w_beat;
            r_res_vld <= '0;
            if (w_beat) begin
                r_in_a <= bus.op_a[{w_sel, 4'b0000} +: 16];
                r_in_b <= bus.op_b[{w_sel, 4'b0000} +: 16];
            end
            case (r_state)
                IDLE: begin
                    if (|bus.req) begin
                        r_gnt  <= w_win ? 2'b10 : 2'b01;
                        r_mode <= bus.req_mode[w_win];
                        r_len  <= bus.req_len[{w_win, 3'b000} +: 8];
                        r_cnt  <= '0;
                        r_conf <= 1'b0;
                    end
                end
                CONF:   r_conf <= 1'b1;
                STREAM: if (w_beat) r_cnt <= r_cnt + 8'd1;
                WAIT: begin
                    // A result only counts while waiting for one; stray valids elsewhere fall through.
                    if (bus.mac_out_valid) begin
                        r_res     <= bus.mac_out;
                        r_res_vld <= r_gnt;
                    end
                end
                DONE: begin
                    r_gnt <= '0;
                    r_pri <= ~w_sel;
                end
                default: ;
            endcase
        end
    end

    assign bus.gnt            = r_gnt;
    assign bus.op_ready       = (r_state == STREAM) ? r_gnt : 2'b00;
    assign bus.mac_config_en  = (r_state == CONF) && !r_conf;
    assign bus.mac_float_int  = r_mode;
    assign bus.mac_data_num   = r_len;
    assign bus.mac_in_a       = r_in_a;
    assign bus.mac_in_b       = r_in_b;
    assign bus.mac_in_valid_a = r_in_vld;
    assign bus.mac_in_valid_b = r_in_vld;
    assign bus.res_data       = r_res;
    assign bus.res_valid      = r_res_vld;
    assign bus.busy           = (r_state != IDLE);

endmodule

// File: tb/tb_mac_arbiter.sv
// Randomized bench for mac_arbiter: a job-level model predicts grants, forwarded beats and results.
module tb_mac_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mac_arbiter_if bus();

`ifdef MAC_ARB_TIMEOUT_EN
    mac_arbiter #(.TIMEOUT_CYC(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
`else
    mac_arbiter dut (.clk(clk), .rst_n(rst_n), .bus(bus));
`endif

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Observed MAC traffic and handshakes, sampled mid-cycle.
    logic [15:0] mon_a[$], mon_b[$];
    int          mon_t[$], acc_t[$];
    int          cfg_cnt, rv_cnt, err_cnt, vmis_cnt;
    logic [1:0]  rv_last, err_last;
    logic [15:0] rd_last;

    always @(negedge clk) begin
        if (bus.mac_in_valid_a || bus.mac_in_valid_b) begin
            if (bus.mac_in_valid_a !== bus.mac_in_valid_b) vmis_cnt++;
            mon_a.push_back(bus.mac_in_a);
            mon_b.push_back(bus.mac_in_b);
            mon_t.push_back(cyc);
        end
        if (|(bus.op_valid & bus.op_ready)) acc_t.push_back(cyc);
        if (bus.mac_config_en) cfg_cnt++;
        if (|bus.res_valid) begin rv_cnt++; rv_last = bus.res_valid; rd_last = bus.res_data; end
        if (|bus.err) begin err_cnt++; err_last = bus.err; end
    end

    // Reference model state: preferred requester and expected beats of the current job.
    int          m_pri = 0;
    logic [15:0] exp_a[$], exp_b[$];
    logic [15:0] exp_sum;

    logic [1:0]  o_gnt, o_rdy_wait, o_gnt_after;
    logic        o_cfg, o_fi, o_busy_wait, o_busy_done, o_busy_after;
    logic [7:0]  o_num;
    int          o_wait_cyc;

    function automatic int predict(input logic [1:0] rq);
        return rq[m_pri] ? m_pri : 1 - m_pri;
    endfunction

    function automatic logic [1:0] onehot(input int g);
        return (g == 1) ? 2'b10 : 2'b01;
    endfunction

    task automatic mon_clear();
        mon_a.delete(); mon_b.delete(); mon_t.delete(); acc_t.delete();
        cfg_cnt = 0; rv_cnt = 0; err_cnt = 0; vmis_cnt = 0;
        rv_last = '0; err_last = '0; rd_last = '0;
    endtask

    // Drives one complete job; vpat 0 = valid always, 1 = every other cycle, 2 = random.
    task automatic do_job(input logic [1:0] rq, input logic [7:0] l0, input logic [7:0] l1,
                          input logic [1:0] md, input int vpat, input bit hold,
                          input bit give_res, input int fa, input int fb);
        int g, n, k, guard, d;
        logic v;
        logic [15:0] a, b;
        logic [7:0] len;
        mon_clear(); exp_a.delete(); exp_b.delete(); exp_sum = '0;
        bus.req = rq; bus.req_len = {l1, l0}; bus.req_mode = md;
        o_gnt = '0; guard = 0;
        while (o_gnt == 2'b00 && guard < 20) begin
            @(posedge clk); #1; o_gnt = bus.gnt; guard++;
        end
        if (o_gnt == 2'b00) return;
        o_cfg = bus.mac_config_en; o_num = bus.mac_data_num; o_fi = bus.mac_float_int;
        bus.mac_out = 16'hDEAD; bus.mac_out_valid = 1'b1;
        if (!hold) bus.req = 2'b00;
        bus.req_len = 16'($urandom); bus.req_mode = 2'($urandom);
        g = o_gnt[1] ? 1 : 0;
        len = g ? l1 : l0;
        n = (len == 8'd0) ? 256 : int'(len);
        k = 0; guard = 0;
        while (k < n && guard < 3000) begin
            v = (vpat == 0) ? 1'b1 : (vpat == 1) ? (guard % 2 == 0) : 1'($urandom_range(0, 1));
            a = (fa >= 0) ? 16'(fa) : 16'($urandom);
            b = (fb >= 0) ? 16'(fb) : 16'($urandom);
            bus.op_a = $urandom; bus.op_b = $urandom; bus.op_valid = 2'b11;
            bus.op_a[g*16 +: 16] = a; bus.op_b[g*16 +: 16] = b; bus.op_valid[g] = v;
            if (v && bus.op_ready[g]) begin
                exp_a.push_back(a); exp_b.push_back(b);
                exp_sum = exp_sum + a * b; k++;
            end
            @(posedge clk); #1; guard++;
            bus.mac_out_valid = 1'b0;
        end
        bus.op_valid = 2'b00;
        o_rdy_wait = bus.op_ready; o_busy_wait = bus.busy;
        o_wait_cyc = 0;
        if (give_res) begin
            d = $urandom_range(0, 4);
            repeat (d) begin @(posedge clk); #1; end
            bus.mac_out = exp_sum; bus.mac_out_valid = 1'b1;
            @(posedge clk); #1;
            bus.mac_out_valid = 1'b0;
        end else begin
            while (bus.err == 2'b00 && o_wait_cyc < 50) begin
                @(posedge clk); #1; o_wait_cyc++;
            end
        end
        o_busy_done = bus.busy;
        @(posedge clk); #1;
        o_busy_after = bus.busy; o_gnt_after = bus.gnt;
        m_pri = 1 - g;
    endtask

    task automatic test_reset();
        bus.req = '0; bus.req_mode = '0; bus.req_len = '0; bus.op_a = '0; bus.op_b = '0;
        bus.op_valid = '0; bus.mac_out_valid = 1'b0; bus.mac_out = '0;
        rst_n = 1'b0;
        #23;
        n_chk++;
        if ({bus.gnt, bus.op_ready, bus.res_valid, bus.err, bus.busy, bus.mac_config_en,
             bus.mac_in_valid_a, bus.mac_in_valid_b} !== '0) begin
            n_fail++; $display("FAIL reset_ctrl: got gnt=%b rdy=%b rv=%b err=%b busy=%b", bus.gnt,
                               bus.op_ready, bus.res_valid, bus.err, bus.busy);
        end
        n_chk++;
        if ({bus.res_data, bus.mac_in_a, bus.mac_in_b, bus.mac_data_num, bus.mac_float_int} !== '0) begin
            n_fail++; $display("FAIL reset_data: got res=%h a=%h b=%h num=%h fi=%b want all 0",
                               bus.res_data, bus.mac_in_a, bus.mac_in_b, bus.mac_data_num, bus.mac_float_int);
        end
        @(negedge clk); rst_n = 1'b1; m_pri = 0;
        repeat (2) @(posedge clk); #1;
        n_chk++;
        if (bus.busy !== 1'b0 || bus.gnt !== 2'b00) begin
            n_fail++; $display("FAIL idle_no_req: got busy=%b gnt=%b want 0/00", bus.busy, bus.gnt);
        end
    endtask

    task automatic test_single();
        int bad;
        do_job(2'b01, 8'd4, 8'd7, 2'b00, 0, 1'b0, 1'b1, 2, 3);
        n_chk++; if (o_gnt !== 2'b01) begin n_fail++; $display("FAIL single_gnt: got %b want 01", o_gnt); end
        n_chk++; if (cfg_cnt !== 1 || o_cfg !== 1'b1) begin n_fail++; $display("FAIL single_cfg: got pulses=%0d first=%b want 1/1", cfg_cnt, o_cfg); end
        n_chk++; if (o_num !== 8'd4 || o_fi !== 1'b0) begin n_fail++; $display("FAIL single_conf: got num=%0d fi=%b want 4/0", o_num, o_fi); end
        bad = (mon_a.size() != 4) ? 1 : 0;
        foreach (mon_a[i]) if (mon_a[i] !== 16'd2 || mon_b[i] !== 16'd3) bad = 1;
        n_chk++; if (bad != 0 || vmis_cnt != 0) begin n_fail++; $display("FAIL single_beats: got %0d beats (mis %0d) want 4 of a=2 b=3", mon_a.size(), vmis_cnt); end
        n_chk++; if (rd_last !== 16'd24 || rv_cnt !== 1 || rv_last !== 2'b01) begin n_fail++; $display("FAIL single_res: got data=%0d pulses=%0d rv=%b want 24/1/01", rd_last, rv_cnt, rv_last); end
        n_chk++; if (o_busy_done !== 1'b1 || o_busy_after !== 1'b0 || o_gnt_after !== 2'b00) begin n_fail++; $display("FAIL single_done: got busy %b->%b gnt=%b want 1->0 00", o_busy_done, o_busy_after, o_gnt_after); end
        n_chk++; if (err_cnt !== 0) begin n_fail++; $display("FAIL single_err: got %0d err pulses want 0", err_cnt); end
    endtask

    task automatic test_round_robin();
        int eg;
        logic [1:0] prev;
        prev = 2'b00;
        for (int j = 0; j < 4; j++) begin
            eg = predict(2'b11);
            do_job(2'b11, 8'd2, 8'd2, 2'b01, 2, 1'b1, 1'b1, -1, -1);
            n_chk++; if (o_gnt !== onehot(eg) || o_gnt === prev) begin n_fail++; $display("FAIL rr_gnt%0d: got %b want %b (prev %b)", j, o_gnt, onehot(eg), prev); end
            n_chk++; if (o_fi !== (eg == 0) || mon_a.size() != 2) begin n_fail++; $display("FAIL rr_job%0d: got fi=%b beats=%0d want %b/2", j, o_fi, mon_a.size(), eg == 0); end
            prev = o_gnt;
        end
        bus.req = 2'b00;
    endtask

    task automatic test_len256();
        int bad;
        do_job(2'b01, 8'd0, 8'd5, 2'b11, 0, 1'b0, 1'b1, -1, -1);
        bad = (mon_a.size() != exp_a.size()) ? 1 : 0;
        foreach (mon_a[i]) if (bad == 0 && (mon_a[i] !== exp_a[i] || mon_b[i] !== exp_b[i])) bad = 1;
        n_chk++; if (mon_a.size() != 256 || bad != 0) begin n_fail++; $display("FAIL len256_beats: got %0d beats bad=%0d want 256 matching", mon_a.size(), bad); end
        n_chk++; if (o_num !== 8'd0 || o_fi !== 1'b1) begin n_fail++; $display("FAIL len256_conf: got num=%0d fi=%b want 0/1", o_num, o_fi); end
        n_chk++; if (o_rdy_wait !== 2'b00 || o_busy_wait !== 1'b1) begin n_fail++; $display("FAIL len256_wait: got rdy=%b busy=%b want 00/1", o_rdy_wait, o_busy_wait); end
        n_chk++; if (rd_last !== exp_sum) begin n_fail++; $display("FAIL len256_res: got %h want %h", rd_last, exp_sum); end
    endtask

    task automatic test_gaps();
        int bad, eg;
        eg = predict(2'b10);
        do_job(2'b10, 8'd9, 8'd3, 2'b00, 1, 1'b0, 1'b1, -1, -1);
        n_chk++; if (o_gnt !== onehot(eg)) begin n_fail++; $display("FAIL gaps_gnt: got %b want %b", o_gnt, onehot(eg)); end
        bad = (mon_t.size() != 3 || acc_t.size() != 3) ? 1 : 0;
        foreach (mon_t[i]) if (bad == 0 && mon_t[i] != acc_t[i] + 1) bad = 1;
        n_chk++; if (bad != 0) begin n_fail++; $display("FAIL gaps_timing: got %0d beats/%0d accepts bad=%0d want 3 each 1 cycle later", mon_t.size(), acc_t.size(), bad); end
        bad = (mon_t.size() == 3 && mon_t[1] - mon_t[0] >= 2 && mon_t[2] - mon_t[1] >= 2) ? 0 : 1;
        n_chk++; if (bad != 0) begin n_fail++; $display("FAIL gaps_spacing: got beats not separated by idle cycles"); end
        bad = 0;
        foreach (mon_a[i]) if (i < exp_a.size() && (mon_a[i] !== exp_a[i] || mon_b[i] !== exp_b[i])) bad = 1;
        n_chk++; if (bad != 0 || rv_last !== 2'b10) begin n_fail++; $display("FAIL gaps_data: got bad=%0d rv=%b want 0/10", bad, rv_last); end
    endtask

    task automatic test_random();
        int eg, bad;
        logic [1:0] rq, md;
        logic [7:0] l0, l1, el;
        for (int j = 0; j < 8; j++) begin
            rq = 2'($urandom_range(1, 3)); md = 2'($urandom);
            l0 = 8'($urandom_range(1, 12)); l1 = 8'($urandom_range(1, 12));
            eg = predict(rq);
            el = (eg == 1) ? l1 : l0;
            do_job(rq, l0, l1, md, 2, 1'b0, 1'b1, -1, -1);
            n_chk++; if (o_gnt !== onehot(eg) || o_num !== el || o_fi !== md[eg]) begin n_fail++; $display("FAIL rand%0d_conf: got gnt=%b num=%0d fi=%b want %b/%0d/%b", j, o_gnt, o_num, o_fi, onehot(eg), el, md[eg]); end
            bad = (mon_a.size() != int'(el) || exp_a.size() != int'(el)) ? 1 : 0;
            foreach (mon_a[i]) if (bad == 0 && (mon_a[i] !== exp_a[i] || mon_b[i] !== exp_b[i] || mon_t[i] != acc_t[i] + 1)) bad = 1;
            n_chk++; if (bad != 0) begin n_fail++; $display("FAIL rand%0d_beats: got %0d beats bad=%0d want %0d", j, mon_a.size(), bad, el); end
            n_chk++; if (rd_last !== exp_sum || rv_cnt !== 1 || rv_last !== onehot(eg)) begin n_fail++; $display("FAIL rand%0d_res: got %h/%0d/%b want %h/1/%b", j, rd_last, rv_cnt, rv_last, exp_sum, onehot(eg)); end
        end
    endtask

    task automatic test_reset_mid();
        int k, guard;
        mon_clear();
        bus.req = 2'b01; bus.req_len = {8'd1, 8'd6}; bus.req_mode = 2'b00;
        bus.op_valid = 2'b01; bus.op_a = 32'h0000_1234; bus.op_b = 32'h0000_5678;
        k = 0; guard = 0;
        while (k < 2 && guard < 40) begin
            @(posedge clk); #1; guard++;
            if (bus.op_ready[0]) k++;
        end
        @(posedge clk); #2;
        rst_n = 1'b0; #1;
        n_chk++;
        if ({bus.gnt, bus.op_ready, bus.res_valid, bus.err, bus.busy, bus.mac_config_en, bus.mac_in_valid_a,
             bus.mac_in_valid_b, bus.res_data, bus.mac_in_a, bus.mac_in_b, bus.mac_data_num, bus.mac_float_int} !== '0) begin
            n_fail++; $display("FAIL midrst_clear: got gnt=%b busy=%b va=%b a=%h num=%h want all 0 (k=%0d)", bus.gnt, bus.busy, bus.mac_in_valid_a, bus.mac_in_a, bus.mac_data_num, k);
        end
        bus.op_valid = 2'b00; bus.req = 2'b00;
        repeat (3) @(posedge clk);
        @(negedge clk); rst_n = 1'b1; m_pri = 0;
        repeat (3) @(posedge clk); #1;
        n_chk++; if (rv_cnt !== 0 || err_cnt !== 0) begin n_fail++; $display("FAIL midrst_pulse: got rv=%0d err=%0d want 0/0", rv_cnt, err_cnt); end
        do_job(2'b10, 8'd3, 8'd1, 2'b00, 0, 1'b0, 1'b1, -1, -1);
        n_chk++; if (o_gnt !== 2'b10 || rv_last !== 2'b10) begin n_fail++; $display("FAIL midrst_regrant: got gnt=%b rv=%b want 10/10", o_gnt, rv_last); end
    endtask

`ifdef MAC_ARB_TIMEOUT_EN
    task automatic test_timeout();
        int eg;
        eg = predict(2'b01);
        do_job(2'b01, 8'd2, 8'd2, 2'b00, 0, 1'b0, 1'b0, -1, -1);
        n_chk++; if (o_wait_cyc != 8 || err_last !== onehot(eg) || err_cnt !== 1) begin n_fail++; $display("FAIL tmo_err: got after %0d cycles err=%b pulses=%0d want 8/%b/1", o_wait_cyc, err_last, err_cnt, onehot(eg)); end
        n_chk++; if (rv_cnt !== 0) begin n_fail++; $display("FAIL tmo_rv: got %0d res_valid pulses want 0", rv_cnt); end
        n_chk++; if (o_busy_done !== 1'b1 || o_busy_after !== 1'b0) begin n_fail++; $display("FAIL tmo_busy: got %b->%b want 1->0", o_busy_done, o_busy_after); end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_len256();
        test_gaps();
        test_random();
        test_reset_mid();
`ifdef MAC_ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
